// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative radix-2 multiply/divide unit with start/busy/done handshake
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic [0:1]       op,
    input  logic [0:WIDTH-1] a,
    input  logic [0:WIDTH-1] b,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [0:WIDTH-1] resHi,
    output logic [0:WIDTH-1] resLo
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t r_state, w_next;

    logic [CW-1:0]      r_cnt;
    logic               r_is_div;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_err;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_dvs;
    logic [WIDTH-1:0]   r_res_hi;
    logic [WIDTH-1:0]   r_res_lo;

    // Ports use bit 0 as MSB; internal vectors are descending with the same numeric value.
    logic [1:0]         w_op;
    logic [WIDTH-1:0]   w_a, w_b;
    logic               w_sgn, w_div;
    logic               w_a_neg, w_b_neg;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b;
    logic               w_div0, w_ovf, w_exc, w_accept;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_trial;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_prod_neg;

    assign w_op    = op;
    assign w_a     = a;
    assign w_b     = b;
    assign w_div   = w_op[1];
    assign w_sgn   = w_op[0];
    assign w_a_neg = w_sgn && w_a[WIDTH-1];
    assign w_b_neg = w_sgn && w_b[WIDTH-1];
    assign w_abs_a = w_a_neg ? -w_a : w_a;
    assign w_abs_b = w_b_neg ? -w_b : w_b;

    assign w_div0   = w_div && (w_b == '0);
    assign w_ovf    = (w_op == 2'b11) && (w_a == {1'b1, {(WIDTH-1){1'b0}}}) && (&w_b);
    assign w_exc    = w_div0 || w_ovf;
    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // Multiply: accumulate into the high half, shift the whole pair right each step.
    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_dvs} : {(WIDTH+1){1'b0}});

    // Divide: bit WIDTH of the trial difference is the borrow, so a clear bit means it fits.
    assign w_shift    = {r_hi, r_lo[WIDTH-1]};
    assign w_trial    = w_shift - {1'b0, r_dvs};
    assign w_ge       = ~w_trial[WIDTH];
    assign w_prod_neg = -{r_hi, r_lo};

    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (start) w_next = w_exc ? S_DONE : S_CALC;
                S_CALC: if (r_cnt == CW'(1)) w_next = S_FIX;
                S_FIX:  w_next = S_DONE;
                S_DONE: w_next = start ? (w_exc ? S_DONE : S_CALC) : S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_err     <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_dvs     <= '0;
            r_res_hi  <= '0;
            r_res_lo  <= '0;
        end else begin
            r_state <= w_next;
            if (!flush) begin
                if (w_accept) begin
                    r_is_div  <= w_div;
                    r_neg_res <= w_a_neg ^ w_b_neg;
                    r_neg_rem <= w_a_neg;
                    r_hi      <= '0;
                    r_lo      <= w_abs_a;
                    r_dvs     <= w_abs_b;
                    if (w_exc) begin
                        r_err    <= 1'b1;
                        r_res_lo <= w_div0 ? {WIDTH{1'b1}} : w_a;
                        r_res_hi <= w_div0 ? w_a : '0;
                    end else begin
                        r_cnt <= CW'(WIDTH);
                    end
                end else if (r_state == S_CALC) begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_is_div) begin
                        r_hi <= w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
                        r_lo <= {r_lo[WIDTH-2:0], w_ge};
                    end else begin
                        r_hi <= w_mul_sum[WIDTH:1];
                        r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
                    end
                end else if (r_state == S_FIX) begin
                    r_err <= 1'b0;
                    if (r_is_div) begin
                        r_res_lo <= r_neg_res ? -r_lo : r_lo;
                        r_res_hi <= r_neg_rem ? -r_hi : r_hi;
                    end else if (r_neg_res) begin
                        {r_res_hi, r_res_lo} <= w_prod_neg;
                    end else begin
                        {r_res_hi, r_res_lo} <= {r_hi, r_lo};
                    end
                end
            end
        end
    end

    assign busy  = (r_state == S_CALC) || (r_state == S_FIX);
    assign done  = (r_state == S_DONE);
    assign err   = r_err;
    assign resHi = r_res_hi;
    assign resLo = r_res_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - self-checking bench for mul_div_unit at WIDTH 32 and 8
module tb_mul_div_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [0:1]  op;
    logic        start32, start8;
    logic [0:31] a32, b32;
    logic [0:7]  a8, b8;
    logic        busy32, done32, err32;
    logic [0:31] hi32, lo32;
    logic        busy8, done8, err8;
    logic [0:7]  hi8, lo8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .flush(flush), .op(op),
        .a(a32), .b(b32), .busy(busy32), .done(done32), .err(err32),
        .resHi(hi32), .resLo(lo32)
    );

    mul_div_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .flush(flush), .op(op),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .err(err8),
        .resHi(hi8), .resLo(lo8)
    );

    typedef struct {
        logic [1:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        e;
    } vec_t;

    // Arithmetic reference: full-width products and truncating signed division on 64-bit integers.
    function automatic void ref_model(input int w, input logic [1:0] o, input logic [31:0] x,
                                      input logic [31:0] y, output logic [31:0] hi,
                                      output logic [31:0] lo, output logic e);
        longint unsigned m, ux, uy, p;
        longint sx, sy, q, r;
        m  = (64'd1 << w) - 64'd1;
        ux = {32'd0, x} & m;
        uy = {32'd0, y} & m;
        sx = (ux > (m >> 1)) ? longint'(ux) - longint'(m) - 64'sd1 : longint'(ux);
        sy = (uy > (m >> 1)) ? longint'(uy) - longint'(m) - 64'sd1 : longint'(uy);
        e  = 1'b0;
        hi = '0;
        lo = '0;
        if (o == 2'b00 || o == 2'b01) begin
            if (o == 2'b00) p = ux * uy;
            else            p = sx * sy;
            hi = 32'((p >> w) & m);
            lo = 32'(p & m);
        end else if (uy == 0) begin
            e  = 1'b1;
            lo = 32'(m);
            hi = 32'(ux);
        end else if (o == 2'b11 && ux == (m >> 1) + 1 && uy == m) begin
            e  = 1'b1;
            lo = 32'(ux);
            hi = '0;
        end else if (o == 2'b10) begin
            lo = 32'(ux / uy);
            hi = 32'(ux % uy);
        end else begin
            q  = sx / sy;
            r  = sx % sy;
            lo = 32'(q & longint'(m));
            hi = 32'(r & longint'(m));
        end
    endfunction

    // Called at #1 after a rising edge (cycle 0); returns #1 after the edge that shows done.
    task automatic do_op(input int w, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] hi, output logic [31:0] lo, output logic e,
                         output int lat, output int nbusy);
        op  = o;
        a32 = x;
        b32 = y;
        a8  = x[7:0];
        b8  = y[7:0];
        if (w == 32) start32 = 1'b1;
        else         start8  = 1'b1;
        lat   = -1;
        nbusy = 0;
        hi    = 'x;
        lo    = 'x;
        e     = 1'bx;
        for (int c = 1; c <= 100 && lat < 0; c++) begin
            @(posedge clk);
            #1;
            start32 = 1'b0;
            start8  = 1'b0;
            if (w == 32 ? busy32 : busy8) nbusy++;
            if (w == 32 ? done32 : done8) begin
                lat = c;
                hi  = (w == 32) ? hi32 : {24'd0, hi8};
                lo  = (w == 32) ? lo32 : {24'd0, lo8};
                e   = (w == 32) ? err32 : err8;
            end
        end
    endtask

    task automatic test_reset();
        checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL reset_busy32 got %b exp 0", busy32); end
        checks++; if (done32 !== 1'b0) begin errors++; $display("FAIL reset_done32 got %b exp 0", done32); end
        checks++; if (err32 !== 1'b0) begin errors++; $display("FAIL reset_err32 got %b exp 0", err32); end
        checks++; if (hi32 !== 32'd0) begin errors++; $display("FAIL reset_hi32 got %h exp 0", hi32); end
        checks++; if (lo32 !== 32'd0) begin errors++; $display("FAIL reset_lo32 got %h exp 0", lo32); end
        checks++; if ({busy8, done8, err8, hi8, lo8} !== 19'd0) begin
            errors++; $display("FAIL reset_dut8 got %h exp 0", {busy8, done8, err8, hi8, lo8});
        end
    endtask

    task automatic run_table(input int w, input vec_t v[$]);
        logic [31:0] hi, lo;
        logic        e;
        int          lat, nb, exp_lat, exp_nb;
        foreach (v[i]) begin
            do_op(w, v[i].o, v[i].x, v[i].y, hi, lo, e, lat, nb);
            exp_lat = v[i].e ? 1 : w + 2;
            exp_nb  = v[i].e ? 0 : w + 1;
            checks++; if (lat !== exp_lat) begin errors++; $display("FAIL dir%0d_%0d_latency got %0d exp %0d", w, i, lat, exp_lat); end
            checks++; if (nb !== exp_nb) begin errors++; $display("FAIL dir%0d_%0d_busy_cycles got %0d exp %0d", w, i, nb, exp_nb); end
            checks++; if (hi !== v[i].hi) begin errors++; $display("FAIL dir%0d_%0d_resHi got %h exp %h", w, i, hi, v[i].hi); end
            checks++; if (lo !== v[i].lo) begin errors++; $display("FAIL dir%0d_%0d_resLo got %h exp %h", w, i, lo, v[i].lo); end
            checks++; if (e !== v[i].e) begin errors++; $display("FAIL dir%0d_%0d_err got %b exp %b", w, i, e, v[i].e); end
        end
    endtask

    task automatic test_directed();
        vec_t v32[$];
        vec_t v8[$];
        v32.push_back('{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0});
        v32.push_back('{2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0});
        v32.push_back('{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0});
        v32.push_back('{2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0});
        v32.push_back('{2'b10, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b1});
        v32.push_back('{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b1});
        v8.push_back('{2'b00, 32'hFF, 32'hFF, 32'hFE, 32'h01, 1'b0});
        v8.push_back('{2'b01, 32'hFD, 32'h07, 32'hFF, 32'hEB, 1'b0});
        v8.push_back('{2'b11, 32'hF9, 32'h02, 32'hFF, 32'hFD, 1'b0});
        v8.push_back('{2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0});
        run_table(32, v32);
        run_table(8, v8);
    endtask

    task automatic test_random(input int w, input int n);
        logic [31:0] x, y, hi, lo, ehi, elo;
        logic [1:0]  o;
        logic        e, ee;
        int          lat, nb, mode;
        for (int i = 0; i < n; i++) begin
            o    = 2'($urandom_range(0, 3));
            x    = $urandom;
            y    = $urandom;
            mode = $urandom_range(0, 9);
            if (mode == 0) y = 32'd0;
            if (mode == 1) begin
                x = (w == 32) ? 32'h80000000 : 32'h80;
                y = 32'hFFFFFFFF;
            end
            if (mode == 2) y = 32'($urandom_range(1, 9));
            ref_model(w, o, x, y, ehi, elo, ee);
            do_op(w, o, x, y, hi, lo, e, lat, nb);
            checks++; if (lat !== (ee ? 1 : w + 2)) begin errors++; $display("FAIL rnd%0d_%0d_latency op %b a %h b %h got %0d", w, i, o, x, y, lat); end
            checks++; if (hi !== ehi) begin errors++; $display("FAIL rnd%0d_%0d_resHi op %b a %h b %h got %h exp %h", w, i, o, x, y, hi, ehi); end
            checks++; if (lo !== elo) begin errors++; $display("FAIL rnd%0d_%0d_resLo op %b a %h b %h got %h exp %h", w, i, o, x, y, lo, elo); end
            checks++; if (e !== ee) begin errors++; $display("FAIL rnd%0d_%0d_err op %b a %h b %h got %b exp %b", w, i, o, x, y, e, ee); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] hi, lo;
        logic        e;
        int          lat, nb;
        do_op(32, 2'b00, 32'd1000, 32'd3000, hi, lo, e, lat, nb);
        do_op(32, 2'b11, 32'hFFFFFF9C, 32'd7, hi, lo, e, lat, nb);
        checks++; if (lat !== 34) begin errors++; $display("FAIL b2b_latency got %0d exp 34", lat); end
        checks++; if (nb !== 33) begin errors++; $display("FAIL b2b_busy_cycles got %0d exp 33", nb); end
        checks++; if (lo !== 32'hFFFFFFF2 || hi !== 32'hFFFFFFFE) begin
            errors++; $display("FAIL b2b_result got %h:%h exp fffffffe:fffffff2", hi, lo);
        end
    endtask

    task automatic test_flush();
        logic [31:0] hi, lo;
        logic        e;
        int          lat, nb;
        int          seen;
        do_op(32, 2'b10, 32'd100, 32'd7, hi, lo, e, lat, nb);
        op = 2'b00; a32 = 32'hDEADBEEF; b32 = 32'h12345678; start32 = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            start32 = 1'b0;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL flush_busy got %b exp 0", busy32); end
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (done32 === 1'b1 || busy32 === 1'b1) seen++;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL flush_no_done got %0d active cycles exp 0", seen); end
        checks++; if (hi32 !== 32'd2 || lo32 !== 32'd14 || err32 !== 1'b0) begin
            errors++; $display("FAIL flush_hold got %h:%h err %b exp 00000002:0000000e err 0", hi32, lo32, err32);
        end
        op = 2'b00; start32 = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0; flush = 1'b0;
        checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL flush_over_start got busy %b exp 0", busy32); end
    endtask

    task automatic test_reset_mid();
        int seen;
        op = 2'b01; a32 = 32'hFFFFFFFD; b32 = 32'd7; start32 = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            start32 = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        checks++; if ({busy32, done32, err32, hi32, lo32} !== 67'd0) begin
            errors++; $display("FAIL reset_mid_outputs got %h exp 0", {busy32, done32, err32, hi32, lo32});
        end
        @(posedge clk); #1;
        rst  = 1'b0;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (done32 === 1'b1 || busy32 === 1'b1) seen++;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL reset_mid_no_done got %0d active cycles exp 0", seen); end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; op = 2'b00;
        start32 = 1'b0; start8 = 1'b0;
        a32 = '0; b32 = '0; a8 = '0; b8 = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_directed();
        test_random(32, 40);
        test_random(8, 60);
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit for the VCPU-32 execution stage, next to the combinational ALU and shift-merge path. It performs unsigned or signed multiply with a double-width product, and unsigned or signed divide with quotient and remainder. It uses one radix-2 step per clock and handshakes with the pipeline via start/busy/done. Width is parametrised; the core default is `WORD_LENGTH`.

## Interface
- WIDTH, default `WORD_LENGTH` (32): operand width. Must be even and ≥ 4.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  accepts a, b, op when the unit is in IDLE or DONE.
- flush  in  1  synchronous abort; returns to IDLE, suppresses done.
- op  in  [0:1]  00 MULU, 01 MULS, 10 DIVU, 11 DIVS.
- a  in  [0:WIDTH-1]  multiplicand / dividend. Bit 0 is the MSB.
- b  in  [0:WIDTH-1]  multiplier / divisor.
- busy  out  1  operation in progress; start is ignored.
- done  out  1  one-cycle pulse; results valid.
- err  out  1  qualified by done; divide-by-zero or signed divide overflow.
- resHi  out  [0:WIDTH-1]  product high word / remainder.
- resLo  out  [0:WIDTH-1]  product low word / quotient.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE + start:
  - Latch op.
  - Take absolute values of a and b for signed ops.
  - Record the result sign (a^b) and the remainder sign (sign of a).
  - Load the step counter with WIDTH and go to CALC.
- Exceptions are detected at start; CALC is skipped and the unit goes straight to DONE with err=1:
  - DIVU/DIVS with b=0: resLo = all ones, resHi = a.
  - DIVS with a = most-negative and b = all ones (-1): resLo = a, resHi = 0.
- CALC, multiply: shift-add over a 2·WIDTH accumulator, one multiplier bit per cycle, LSB first.
- CALC, divide: restoring division, one quotient bit per cycle, MSB first. Trial subtract is WIDTH+1 bits wide.
- The counter decrements each CALC cycle; at 0 the unit goes to FIX.
- FIX, signed multiply: 2·WIDTH two's-complement negate of the product if the sign is negative.
- FIX, signed divide: quotient negated if a^b; remainder takes the sign of the dividend (truncating division).
- FIX registers resHi/resLo, then goes to DONE.
- DONE: done=1 for exactly one cycle. Without start the next state is IDLE.
- resHi, resLo and err hold until the next accepted start.
- Unsigned ops: no sign fixup; the full 2·WIDTH product never overflows.
- flush in any state → IDLE at the next edge. done stays 0; results keep their prior values. flush has priority over start in the same cycle.
- start while busy=1 is ignored; no queueing.

## Timing
- Reset values: state IDLE, busy 0, done 0, err 0, resHi 0, resLo 0, counter 0.
- Reset mid-operation aborts immediately with no done.
- Normal op, start high in cycle 0:
  - busy high in cycles 1..WIDTH+1.
  - done high in cycle WIDTH+2 (34 for WIDTH=32).
- Exception op: done and err high in cycle 1; busy stays low.
- Back-to-back: start may be asserted in the done cycle. It is accepted, and busy rises in the next cycle.
- Throughput: one op per WIDTH+2 cycles.

## Test plan
- MULU a=0xFFFFFFFF, b=0xFFFFFFFF, start in cycle 0 → done in cycle 34, resHi=0xFFFFFFFE, resLo=0x00000001, err=0. busy high in cycles 1–33 only.
- MULS a=0xFFFFFFFD (-3), b=7 → resHi=0xFFFFFFFF, resLo=0xFFFFFFEB (-21).
- DIVS a=0xFFFFFFF9 (-7), b=2 → resLo=0xFFFFFFFD (-3), resHi=0xFFFFFFFF (-1).
- DIVU a=100, b=7 → resLo=14, resHi=2.
- DIVU a=0x12345678, b=0 → done and err in cycle 1, resLo=0xFFFFFFFF, resHi=0x12345678.
- DIVS a=0x80000000, b=0xFFFFFFFF → err=1, resLo=0x80000000, resHi=0.
- Flush at cycle 10 of a MULU → IDLE in cycle 11, no done, prior results unchanged.
- rst asserted mid-CALC → all outputs 0 asynchronously.
- start in the done cycle → second result after WIDTH+2 further cycles.
- Repeat the MULU, MULS, DIVS and DIVU cases with WIDTH=8, with done in cycle 10.
